// File: rtl/axi_sram_wr_bridge_pkg.sv
// axi_sram_wr_bridge_pkg: shared widths, state encodings, BRESP and burst codes for the SRAM write bridge
package axi_sram_wr_bridge_pkg;
   localparam int BUS_WIDTH  = 32;
   localparam int DATA_WIDTH = 32;
   localparam int Lawaddr    = 32;
   localparam int Lawid      = 4;
   localparam int Lwid       = 4;
   localparam int Lbid       = 4;
   localparam int Lawlen     = 4;
   localparam int Lawsize    = 3;
   localparam int Lawburst   = 2;
   localparam int Lawcache   = 4;
   localparam int Lawlock    = 2;
   localparam int Lawprot    = 3;
   localparam int Lwdata     = 32;
   localparam int Lwstrb     = 4;
   localparam int Lbresp     = 2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DATA = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic [Lbresp-1:0]   BRESP_OKAY   = 2'b00;
   localparam logic [Lbresp-1:0]   BRESP_SLVERR = 2'b10;

   localparam logic [Lawburst-1:0] BURST_FIXED  = 2'b00;
   localparam logic [Lawburst-1:0] BURST_INCR   = 2'b01;
   localparam logic [Lawburst-1:0] BURST_WRAP   = 2'b10;
   localparam logic [Lawburst-1:0] BURST_RSVD   = 2'b11;

   // the SRAM port only supports FIXED/INCR beats no wider than the 32-bit data bus
   function automatic logic burst_bad(input logic [Lawburst-1:0] burst, input logic [Lawsize-1:0] size);
      return (burst == BURST_WRAP) || (burst == BURST_RSVD) || (size > 3'd2);
   endfunction
endpackage

// File: rtl/axi_wr_beat_gen.sv
// axi_wr_beat_gen: per-beat byte address and beat counter for one AXI write burst
module axi_wr_beat_gen
   import axi_sram_wr_bridge_pkg::*;
(
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_load,
   input  logic                i_advance,
   input  logic [Lawaddr-1:0]  i_addr,
   input  logic [Lawsize-1:0]  i_size,
   input  logic [Lawburst-1:0] i_burst,
   input  logic [Lawlen-1:0]   i_len,
   output logic [Lawaddr-1:0]  o_addr,
   output logic                o_last
);
   logic [Lawaddr-1:0]  r_addr, w_addr_nxt, w_step;
   logic [Lawlen-1:0]   r_cnt, r_len, w_cnt_nxt;
   logic [Lawsize-1:0]  r_size;
   logic [Lawburst-1:0] r_burst;
   logic                w_en;

   // load restarts at beat 0; each accepted beat steps INCR by the transfer size and leaves FIXED in place
   always_comb begin
      w_en       = i_load | i_advance;
      w_step     = (r_burst == BURST_INCR) ? (Lawaddr'(1) << r_size) : '0;
      w_addr_nxt = i_load ? i_addr : r_addr + w_step;
      w_cnt_nxt  = i_load ? '0 : r_cnt + Lawlen'(1);
      o_addr     = r_addr;
      o_last     = r_cnt == r_len;
   end

   dffre #(.W(Lawaddr)) u_addr (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(w_en), .i_d(w_addr_nxt), .o_q(r_addr)
   );

   dffre #(.W(Lawlen)) u_cnt (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(w_en), .i_d(w_cnt_nxt), .o_q(r_cnt)
   );

   dffre #(.W(Lawlen + Lawsize + Lawburst)) u_ctl (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_load),
      .i_d({i_len, i_size, i_burst}), .o_q({r_len, r_size, r_burst})
   );
endmodule

// File: rtl/dffre.sv
// dffre: common flop cell with asynchronous active-low clear and load enable
module dffre #(
   parameter int W = 1
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_en,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);
   // clear on reset, otherwise load only when enabled
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) o_q <= '0;
      else if (i_en) o_q <= i_d;
endmodule

// File: rtl/axi_sram_wr_bridge.sv
// axi_sram_wr_bridge: single-outstanding AXI write slave driving a byte-enabled SRAM write port
module axi_sram_wr_bridge
   import axi_sram_wr_bridge_pkg::*;
(
   input  logic                    aclk,
   input  logic                    aresetn,
   output logic [BUS_WIDTH-1:0]    ram_waddr,
   output logic [DATA_WIDTH-1:0]   ram_wdata,
   output logic [DATA_WIDTH/8-1:0] ram_wen,
   input  logic [Lawaddr-1:0]      m_awaddr,
   input  logic [Lawid-1:0]        m_awid,
   input  logic [Lawlen-1:0]       m_awlen,
   input  logic [Lawsize-1:0]      m_awsize,
   input  logic [Lawburst-1:0]     m_awburst,
   input  logic [Lawcache-1:0]     m_awcache,
   input  logic [Lawlock-1:0]      m_awlock,
   input  logic [Lawprot-1:0]      m_awprot,
   input  logic                    m_awvalid,
   output logic                    m_awready,
   input  logic [Lwdata-1:0]       m_wdata,
   input  logic [Lwstrb-1:0]       m_wstrb,
   input  logic [Lwid-1:0]         m_wid,
   input  logic                    m_wlast,
   input  logic                    m_wvalid,
   output logic                    m_wready,
   output logic [Lbid-1:0]         m_bid,
   output logic [Lbresp-1:0]       m_bresp,
   output logic                    m_bvalid,
   input  logic                    m_bready
);
   logic [1:0]         r_state, w_state_nxt;
   logic [Lawid-1:0]   r_id;
   logic               r_bad, r_err, w_err_nxt;
   logic               w_aw_hs, w_w_hs, w_b_hs, w_last;
   logic [Lawaddr-1:0] w_addr;
   logic               w_unused;

   assign w_unused = ^{m_awcache, m_awlock, m_awprot};

   // handshakes from state; error restarts clean per burst and latches any wlast or wid slip
   always_comb begin
      w_aw_hs   = m_awvalid & (r_state == S_IDLE);
      w_w_hs    = m_wvalid & (r_state == S_DATA);
      w_b_hs    = m_bready & (r_state == S_RESP);
      w_err_nxt = w_aw_hs ? 1'b0 : r_err | (w_w_hs & ((m_wlast != w_last) | (m_wid != r_id)));
   end

   // burst ends on the beat count alone, never on wlast
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  w_state_nxt = w_aw_hs ? S_DATA : S_IDLE;
         S_DATA:  w_state_nxt = (w_w_hs & w_last) ? S_RESP : S_DATA;
         S_RESP:  w_state_nxt = w_b_hs ? S_IDLE : S_RESP;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ready/valid per state; unsupported bursts consume beats without touching the SRAM
   always_comb begin
      m_awready = r_state == S_IDLE;
      m_wready  = r_state == S_DATA;
      m_bvalid  = r_state == S_RESP;
      m_bid     = r_id;
      m_bresp   = (r_err | r_bad) ? BRESP_SLVERR : BRESP_OKAY;
      ram_waddr = w_addr;
      ram_wdata = m_wdata;
      ram_wen   = (w_w_hs & ~r_bad) ? m_wstrb : '0;
   end

   dffre #(.W(2)) u_state (
      .i_clk(aclk), .i_rst_n(aresetn), .i_en(1'b1), .i_d(w_state_nxt), .o_q(r_state)
   );

   dffre #(.W(Lawid)) u_id (
      .i_clk(aclk), .i_rst_n(aresetn), .i_en(w_aw_hs), .i_d(m_awid), .o_q(r_id)
   );

   dffre #(.W(1)) u_bad (
      .i_clk(aclk), .i_rst_n(aresetn), .i_en(w_aw_hs),
      .i_d(burst_bad(m_awburst, m_awsize)), .o_q(r_bad)
   );

   dffre #(.W(1)) u_err (
      .i_clk(aclk), .i_rst_n(aresetn), .i_en(1'b1), .i_d(w_err_nxt), .o_q(r_err)
   );

   axi_wr_beat_gen u_beat (
      .i_clk(aclk), .i_rst_n(aresetn), .i_load(w_aw_hs), .i_advance(w_w_hs),
      .i_addr(m_awaddr), .i_size(m_awsize), .i_burst(m_awburst), .i_len(m_awlen),
      .o_addr(w_addr), .o_last(w_last)
   );
endmodule

// File: tb/tb_axi_sram_wr_bridge.sv
// tb_axi_sram_wr_bridge: directed vector table, reset/stall sequences and random bursts against a burst-level model
module tb_axi_sram_wr_bridge;
   logic        aclk = 1'b0, aresetn = 1'b0;
   logic [31:0] ram_waddr, ram_wdata;
   logic [3:0]  ram_wen;
   logic [31:0] m_awaddr;
   logic [3:0]  m_awid, m_awlen, m_awcache;
   logic [2:0]  m_awsize, m_awprot;
   logic [1:0]  m_awburst, m_awlock;
   logic        m_awvalid, m_awready;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb, m_wid;
   logic        m_wlast, m_wvalid, m_wready;
   logic [3:0]  m_bid;
   logic [1:0]  m_bresp;
   logic        m_bvalid, m_bready;

   always #5 aclk = ~aclk;

   axi_sram_wr_bridge dut (
      .aclk(aclk), .aresetn(aresetn),
      .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_wen(ram_wen),
      .m_awaddr(m_awaddr), .m_awid(m_awid), .m_awlen(m_awlen), .m_awsize(m_awsize),
      .m_awburst(m_awburst), .m_awcache(m_awcache), .m_awlock(m_awlock), .m_awprot(m_awprot),
      .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wid(m_wid), .m_wlast(m_wlast),
      .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
   );

   int          n_tests = 0, n_fail = 0, dcyc;
   logic [31:0] wq_addr[$], wq_data[$], ex_addr[$], ex_data[$];
   logic [3:0]  wq_wen[$], ex_wen[$];
   logic [31:0] t_addr;
   logic [3:0]  t_id, t_len;
   logic [2:0]  t_size;
   logic [1:0]  t_burst, exp_bresp;
   logic [15:0] t_wlast, t_widbad;
   int          t_bdelay;
   bit          t_gaps;
   logic [31:0] data_a[16];
   logic [3:0]  strb_a[16];

   typedef struct {
      logic [31:0]  addr;
      logic [3:0]   id, len;
      logic [2:0]   size;
      logic [1:0]   burst;
      logic [31:0]  data0;
      logic [15:0]  strb4, wlast, widbad;
      int           bdelay;
      bit           pre_w;
      logic [1:0]   e_bresp;
      int           e_nwr;
      logic [127:0] e_addr;
   } vec_t;
   vec_t vt[11];

   always @(negedge aclk)
      if (aresetn && ram_wen != 4'h0) begin
         wq_addr.push_back(ram_waddr);
         wq_data.push_back(ram_wdata);
         wq_wen.push_back(ram_wen);
      end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge aclk);
      #1;
   endtask

   task automatic clear_wq();
      wq_addr.delete();
      wq_data.delete();
      wq_wen.delete();
   endtask

   // expected SRAM writes and response straight from the burst rules
   task automatic model_build();
      logic bad, err;
      logic [31:0] off;
      bad = (t_burst == 2'b10) || (t_burst == 2'b11) || (t_size > 3'd2);
      err = bad;
      ex_addr.delete();
      ex_data.delete();
      ex_wen.delete();
      for (int i = 0; i <= int'(t_len); i++) begin
         if (t_wlast[i] != (i == int'(t_len))) err = 1'b1;
         if (t_widbad[i]) err = 1'b1;
         off = (t_burst == 2'b01) ? (32'(i) << t_size) : 32'd0;
         if (!bad) begin
            ex_addr.push_back(t_addr + off);
            ex_data.push_back(data_a[i]);
            ex_wen.push_back(strb_a[i]);
         end
      end
      exp_bresp = err ? 2'b10 : 2'b00;
   endtask

   task automatic model_compare(input string tag);
      chk({tag, "_nwr"}, 64'(wq_addr.size()), 64'(ex_addr.size()));
      for (int i = 0; i < ex_addr.size() && i < wq_addr.size(); i++) begin
         chk({tag, "_addr"}, 64'(wq_addr[i]), 64'(ex_addr[i]));
         chk({tag, "_data_wen"}, 64'({wq_data[i], wq_wen[i]}), 64'({ex_data[i], ex_wen[i]}));
      end
   endtask

   // drives one full AW / W / B transaction from the t_* fields
   task automatic run_txn();
      int n;
      clear_wq();
      m_bready  = 1'b0;
      m_awaddr  = t_addr;
      m_awid    = t_id;
      m_awlen   = t_len;
      m_awsize  = t_size;
      m_awburst = t_burst;
      m_awcache = 4'($urandom);
      m_awlock  = 2'($urandom);
      m_awprot  = 3'($urandom);
      m_awvalid = 1'b1;
      n = 0;
      while (!m_awready && n < 50) begin cyc(); n++; end
      chk("aw_ready", 64'(m_awready), 64'(1));
      cyc();
      m_awvalid = 1'b0;
      chk("aw_stall_busy", 64'(m_awready), 64'(0));
      dcyc = 0;
      for (int i = 0; i <= int'(t_len); i++) begin
         if (t_gaps && $urandom_range(0, 2) == 0) begin
            m_wvalid = 1'b0;
            cyc();
            dcyc++;
         end
         m_wvalid = 1'b1;
         m_wdata  = data_a[i];
         m_wstrb  = strb_a[i];
         m_wlast  = t_wlast[i];
         m_wid    = t_widbad[i] ? t_id ^ 4'($urandom_range(1, 15)) : t_id;
         n = 0;
         while (!m_wready && n < 50) begin cyc(); n++; dcyc++; end
         chk("w_ready", 64'(m_wready), 64'(1));
         cyc();
         dcyc++;
      end
      m_wvalid = 1'b0;
      chk("resp_after_last_beat", 64'({m_wready, m_bvalid}), 64'(2'b01));
      for (int k = 0; k < t_bdelay; k++) begin
         chk("b_hold", 64'({m_bvalid, m_bid, m_bresp}), 64'({1'b1, t_id, exp_bresp}));
         cyc();
      end
      n = 0;
      while (!m_bvalid && n < 50) begin cyc(); n++; end
      chk("bvalid", 64'(m_bvalid), 64'(1));
      chk("bid", 64'(m_bid), 64'(t_id));
      chk("bresp", 64'(m_bresp), 64'(exp_bresp));
      chk("aw_stall_resp", 64'(m_awready), 64'(0));
      m_bready = 1'b1;
      cyc();
      m_bready = 1'b0;
      chk("b_done_idle", 64'({m_bvalid, m_awready}), 64'(2'b01));
   endtask

   initial begin
      vt[0]  = '{32'h100, 4'd3, 4'd0, 3'd2, 2'b01, 32'hDEADBEEF, 16'h000F, 16'h0001, 16'h0, 0, 1'b0,
                 2'b00, 1, {96'h0, 32'h100}};
      vt[1]  = '{32'h1FC, 4'd5, 4'd3, 3'd2, 2'b01, 32'h11111111, 16'h1C3F, 16'h0008, 16'h0, 0, 1'b0,
                 2'b00, 4, {32'h208, 32'h204, 32'h200, 32'h1FC}};
      vt[2]  = '{32'h40, 4'd1, 4'd2, 3'd2, 2'b00, 32'h22222222, 16'h0FFF, 16'h0004, 16'h0, 0, 1'b0,
                 2'b00, 3, {32'h0, 32'h40, 32'h40, 32'h40}};
      vt[3]  = '{32'h80, 4'd2, 4'd1, 3'd2, 2'b10, 32'h33333333, 16'h00FF, 16'h0002, 16'h0, 0, 1'b0,
                 2'b10, 0, 128'h0};
      vt[4]  = '{32'h300, 4'd7, 4'd3, 3'd2, 2'b01, 32'h44444444, 16'hFFFF, 16'h0002, 16'h0, 5, 1'b0,
                 2'b10, 4, {32'h30C, 32'h308, 32'h304, 32'h300}};
      vt[5]  = '{32'hFFFFFFFC, 4'd9, 4'd1, 3'd2, 2'b01, 32'h55555555, 16'h00FF, 16'h0002, 16'h0, 0, 1'b1,
                 2'b00, 2, {64'h0, 32'h0, 32'hFFFFFFFC}};
      vt[6]  = '{32'h10, 4'hA, 4'd15, 3'd0, 2'b01, 32'h66666666, 16'h1248, 16'h8000, 16'h0, 0, 1'b0,
                 2'b00, 16, {32'h13, 32'h12, 32'h11, 32'h10}};
      vt[7]  = '{32'h500, 4'd4, 4'd1, 3'd2, 2'b01, 32'h77777777, 16'h00FF, 16'h0002, 16'h0002, 0, 1'b0,
                 2'b10, 2, {64'h0, 32'h504, 32'h500}};
      vt[8]  = '{32'h600, 4'd6, 4'd1, 3'd3, 2'b01, 32'h88888888, 16'h00FF, 16'h0002, 16'h0, 0, 1'b0,
                 2'b10, 0, 128'h0};
      vt[9]  = '{32'h700, 4'd8, 4'd0, 3'd2, 2'b11, 32'h99999999, 16'h000F, 16'h0001, 16'h0, 0, 1'b0,
                 2'b10, 0, 128'h0};
      vt[10] = '{32'h2, 4'hB, 4'd2, 3'd1, 2'b01, 32'hAAAAAAAA, 16'h0C63, 16'h0004, 16'h0, 0, 1'b0,
                 2'b00, 3, {32'h0, 32'h6, 32'h4, 32'h2}};

      m_awaddr = '0; m_awid = '0; m_awlen = '0; m_awsize = '0; m_awburst = '0;
      m_awcache = '0; m_awlock = '0; m_awprot = '0; m_awvalid = 1'b0;
      m_wdata = '0; m_wstrb = '0; m_wid = '0; m_wlast = 1'b0; m_wvalid = 1'b0; m_bready = 1'b0;
      repeat (3) cyc();
      chk("reset_outputs", 64'({m_wready, m_bvalid, m_bresp, m_bid, ram_wen}), 64'(0));
      aresetn = 1'b1;
      #1;
      chk("reset_awready", 64'(m_awready), 64'(1));
      cyc();

      for (int v = 0; v < 11; v++) begin
         t_addr = vt[v].addr; t_id = vt[v].id; t_len = vt[v].len; t_size = vt[v].size;
         t_burst = vt[v].burst; t_wlast = vt[v].wlast; t_widbad = vt[v].widbad;
         t_bdelay = vt[v].bdelay; t_gaps = 1'b0; exp_bresp = vt[v].e_bresp;
         for (int i = 0; i < 16; i++) begin
            data_a[i] = (i == 0) ? vt[v].data0 : $urandom;
            strb_a[i] = (i < 4) ? vt[v].strb4[i*4 +: 4] : 4'($urandom_range(1, 15));
         end
         if (vt[v].pre_w) begin
            m_wvalid = 1'b1; m_wdata = 32'hBADBAD00; m_wstrb = 4'hF; m_wid = t_id; m_wlast = 1'b1;
            for (int k = 0; k < 2; k++) begin
               chk($sformatf("vec%0d_pre_w_stall", v), 64'({m_wready, ram_wen}), 64'(0));
               cyc();
            end
         end
         run_txn();
         chk($sformatf("vec%0d_data_cycles", v), 64'(dcyc), 64'(int'(t_len) + 1));
         chk($sformatf("vec%0d_nwr", v), 64'(wq_addr.size()), 64'(vt[v].e_nwr));
         for (int i = 0; i < vt[v].e_nwr && i < 4 && i < wq_addr.size(); i++) begin
            chk($sformatf("vec%0d_addr%0d", v, i), 64'(wq_addr[i]), 64'(vt[v].e_addr[i*32 +: 32]));
            chk($sformatf("vec%0d_wen%0d", v, i), 64'(wq_wen[i]), 64'(strb_a[i]));
            chk($sformatf("vec%0d_data%0d", v, i), 64'(wq_data[i]), 64'(data_a[i]));
         end
      end

      clear_wq();
      m_awaddr = 32'h800; m_awid = 4'hC; m_awlen = 4'd7; m_awsize = 3'd2; m_awburst = 2'b01;
      m_awvalid = 1'b1;
      chk("rst_seq_aw", 64'(m_awready), 64'(1));
      cyc();
      m_awvalid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         m_wvalid = 1'b1; m_wdata = 32'hA0 + 32'(i); m_wstrb = 4'hF; m_wid = 4'hC; m_wlast = 1'b0;
         chk("rst_seq_wready", 64'(m_wready), 64'(1));
         cyc();
      end
      m_wdata = 32'hA2;
      chk("rst_seq_beat2_live", 64'(ram_wen), 64'(4'hF));
      aresetn = 1'b0;
      #1;
      chk("rst_seq_async", 64'({ram_wen, m_bvalid, m_wready}), 64'(0));
      cyc();
      chk("rst_seq_hold", 64'({ram_wen, m_bvalid, m_wready, m_bresp, m_bid}), 64'(0));
      m_wvalid = 1'b0;
      aresetn = 1'b1;
      #1;
      chk("rst_seq_release", 64'({m_awready, m_wready, m_bvalid}), 64'(3'b100));
      chk("rst_seq_nwr", 64'(wq_addr.size()), 64'(2));
      if (wq_addr.size() == 2) chk("rst_seq_addr1", 64'({wq_addr[1], wq_data[1][7:0]}), 64'({32'h804, 8'hA1}));
      cyc();
      t_addr = 32'h900; t_id = 4'h2; t_len = 4'd0; t_size = 3'd2; t_burst = 2'b01;
      t_wlast = 16'h0001; t_widbad = 16'h0; t_bdelay = 0; t_gaps = 1'b0;
      data_a[0] = 32'hC0FFEE00; strb_a[0] = 4'hF;
      model_build();
      chk("post_rst_expect_okay", 64'(exp_bresp), 64'(2'b00));
      run_txn();
      model_compare("post_rst");

      for (int r = 0; r < 60; r++) begin
         t_addr  = ($urandom_range(0, 4) == 0) ? 32'hFFFFFFF0 + 32'($urandom_range(0, 15)) : $urandom;
         t_id    = 4'($urandom);
         t_len   = 4'($urandom);
         t_size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
         t_burst = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
         t_wlast = 16'(1) << t_len;
         if ($urandom_range(0, 9) == 0) t_wlast[$urandom_range(0, int'(t_len))] ^= 1'b1;
         t_widbad = ($urandom_range(0, 9) == 0) ? 16'(1) << $urandom_range(0, int'(t_len)) : 16'h0;
         t_bdelay = $urandom_range(0, 3);
         t_gaps   = 1'($urandom);
         for (int i = 0; i < 16; i++) begin
            data_a[i] = $urandom;
            strb_a[i] = 4'($urandom_range(1, 15));
         end
         model_build();
         run_txn();
         model_compare($sformatf("rnd%0d", r));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
